// File: rtl/attn_result_serializer_if.sv
// Bus bundle between the result serializer, the result BRAM read port,
// the attention core completion flag and the downstream serial stream.
interface attn_result_serializer_if #(
  parameter int unsigned LINES  = 64,
  parameter int unsigned COLS   = 8,
  parameter int unsigned WORD_W = 4096,
  parameter int unsigned LANES  = 1
);

  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

  // Attention core
  logic              I_ATTN_END;

  // BRAM read port
  logic              O_RD_BRAM_EN;
  logic [LINE_W-1:0] O_RD_BRAM_LINE;
  logic [COL_W-1:0]  O_RD_BRAM_COL;
  logic              I_BRAM_RD_VLD;
  logic [WORD_W-1:0] I_BRAM_RD_MAT;

  // Serial stream
  logic              O_SER_VLD;
  logic [LANES-1:0]  O_SER_DATA;
  logic              I_SER_RDY;
  logic              O_SER_LAST;

  // Status
  logic              O_BUSY;
  logic              O_DONE;

  // Serializer side
  modport master (
    input  I_ATTN_END,
    input  I_BRAM_RD_VLD,
    input  I_BRAM_RD_MAT,
    input  I_SER_RDY,
    output O_RD_BRAM_EN,
    output O_RD_BRAM_LINE,
    output O_RD_BRAM_COL,
    output O_SER_VLD,
    output O_SER_DATA,
    output O_SER_LAST,
    output O_BUSY,
    output O_DONE
  );

  // Environment side (core, BRAM, stream sink)
  modport slave (
    output I_ATTN_END,
    output I_BRAM_RD_VLD,
    output I_BRAM_RD_MAT,
    output I_SER_RDY,
    input  O_RD_BRAM_EN,
    input  O_RD_BRAM_LINE,
    input  O_RD_BRAM_COL,
    input  O_SER_VLD,
    input  O_SER_DATA,
    input  O_SER_LAST,
    input  O_BUSY,
    input  O_DONE
  );

endinterface

// File: rtl/attn_result_serializer.sv
// Readback engine for the flash-attention result BRAM. After the attention
// core raises its completion level, every line/column word is read once and
// shifted out LANES bits per beat on a valid/ready stream. The final beat of
// the final word carries O_SER_LAST; dropping I_ATTN_END mid-readout aborts.
module attn_result_serializer #(
  parameter int unsigned LINES     = 64,
  parameter int unsigned COLS      = 8,
  parameter int unsigned WORD_W    = 4096,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic                   I_CLK,
  input logic                   I_RST_N,
  attn_result_serializer_if.master bus
);

  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BEATS  = WORD_W / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Geometry sanity, caught at elaboration
  if ((WORD_W % LANES) != 0) begin : g_bad_lanes
    $error("attn_result_serializer: WORD_W must be a multiple of LANES");
  end
  if ((LINES < 1) || (COLS < 1)) begin : g_bad_geometry
    $error("attn_result_serializer: LINES and COLS must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StShift,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                attn_q;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;
  logic [COL_W-1:0]    rd_col_q, rd_col_d;

  logic attn_rise;
  logic is_last_beat;
  logic is_last_col;
  logic is_last_line;

  assign attn_rise    = bus.I_ATTN_END & ~attn_q;
  assign is_last_beat = (beat_q == LAST_BEAT);
  assign is_last_col  = (col_q == LAST_COL);
  assign is_last_line = (line_q == LAST_LINE);

  // Next-state logic: walk line/col, capture each word, shift it out
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    col_d     = col_q;
    beat_d    = beat_q;
    shift_d   = shift_q;
    rd_line_d = rd_line_q;
    rd_col_d  = rd_col_q;

    unique case (state_q)
      StIdle: begin
        if (attn_rise) begin
          line_d  = '0;
          col_d   = '0;
          state_d = StReq;
        end
      end

      StReq: begin
        state_d = StWait;
      end

      StWait: begin
        if (bus.I_BRAM_RD_VLD) begin
          shift_d = bus.I_BRAM_RD_MAT;
          beat_d  = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        if (bus.I_SER_RDY) begin
          // Move the next LANES bits toward the output end
          shift_d = MSB_FIRST ? (shift_q << LANES) : (shift_q >> LANES);
          beat_d  = beat_q + BEAT_W'(1);
          if (is_last_beat) begin
            beat_d = '0;
            if (is_last_col && is_last_line) begin
              state_d = StDone;
            end else if (is_last_col) begin
              col_d   = '0;
              line_d  = line_q + LINE_W'(1);
              state_d = StReq;
            end else begin
              col_d   = col_q + COL_W'(1);
              state_d = StReq;
            end
          end
        end
      end

      StDone: begin
        if (!bus.I_ATTN_END) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort: completion level withdrawn while the readout is active
    if (((state_q == StReq) || (state_q == StWait) || (state_q == StShift)) &&
        !bus.I_ATTN_END) begin
      state_d = StIdle;
      line_d  = '0;
      col_d   = '0;
      beat_d  = '0;
    end

    // Address ports are captured on REQ entry and held until the next REQ
    if (state_d == StReq) begin
      rd_line_d = line_d;
      rd_col_d  = col_d;
    end
  end

  // State, counters, shift register and completion-level edge register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q   <= StIdle;
      attn_q    <= 1'b0;
      line_q    <= '0;
      col_q     <= '0;
      beat_q    <= '0;
      shift_q   <= '0;
      rd_line_q <= '0;
      rd_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      attn_q    <= bus.I_ATTN_END;
      line_q    <= line_d;
      col_q     <= col_d;
      beat_q    <= beat_d;
      shift_q   <= shift_d;
      rd_line_q <= rd_line_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    bus.O_RD_BRAM_EN   = (state_q == StReq);
    bus.O_RD_BRAM_LINE = rd_line_q;
    bus.O_RD_BRAM_COL  = rd_col_q;
    bus.O_SER_VLD      = (state_q == StShift);
    bus.O_SER_DATA     = '0;
    if (state_q == StShift) begin
      bus.O_SER_DATA = MSB_FIRST ? shift_q[WORD_W-1 -: LANES] : shift_q[LANES-1:0];
    end
    bus.O_SER_LAST     = (state_q == StShift) & is_last_beat & is_last_col & is_last_line;
    bus.O_BUSY         = (state_q == StReq) | (state_q == StWait) | (state_q == StShift);
    bus.O_DONE         = (state_q == StDone);
  end

endmodule

// File: tb/tb_attn_result_serializer.sv
// Scoreboard bench for attn_result_serializer: a 2x2 LSB-first instance with
// a 2-cycle BRAM model, plus a 1x1 MSB-first instance.
module tb_attn_result_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  attn_result_serializer_if #(.LINES(2), .COLS(2), .WORD_W(8), .LANES(2)) bus0 ();
  attn_result_serializer_if #(.LINES(1), .COLS(1), .WORD_W(8), .LANES(2)) bus1 ();

  attn_result_serializer #(
    .LINES(2), .COLS(2), .WORD_W(8), .LANES(2), .MSB_FIRST(1'b0)
  ) dut0 (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (bus0)
  );

  attn_result_serializer #(
    .LINES(1), .COLS(1), .WORD_W(8), .LANES(2), .MSB_FIRST(1'b1)
  ) dut1 (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // BRAM model for dut0: word index {line,col}, 2-cycle read latency
  logic [7:0] mem [4];
  logic       p1_vld  = 1'b0;
  logic       p2_vld  = 1'b0;
  logic [1:0] p1_addr = 2'd0;
  logic [7:0] p2_data = 8'd0;
  logic       spur    = 1'b0;
  always @(posedge clk) begin
    p1_vld  <= bus0.O_RD_BRAM_EN;
    p1_addr <= {bus0.O_RD_BRAM_LINE, bus0.O_RD_BRAM_COL};
    p2_vld  <= p1_vld;
    p2_data <= mem[p1_addr];
  end
  assign bus0.I_BRAM_RD_VLD = p2_vld | spur;
  assign bus0.I_BRAM_RD_MAT = spur ? 8'hFF : p2_data;

  // BRAM model for dut1: single word 0xA5, 1-cycle latency
  logic vld1 = 1'b0;
  always @(posedge clk) vld1 <= bus1.O_RD_BRAM_EN;
  assign bus1.I_BRAM_RD_VLD = vld1;
  assign bus1.I_BRAM_RD_MAT = 8'hA5;

  // Ready driver: free-running 1,0,0,1 pattern or held level
  logic bp_mode  = 1'b0;
  logic rdy_hold = 1'b0;
  int   bp_k     = 0;
  initial begin
    bus0.I_SER_RDY = 1'b1;
    bus1.I_SER_RDY = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode) begin
        bus0.I_SER_RDY = (bp_k == 0) || (bp_k == 3);
        bp_k = (bp_k + 1) % 4;
      end else begin
        bus0.I_SER_RDY = !rdy_hold;
      end
    end
  end

  // Scoreboard state
  logic [2:0] exp_beats [$];  // {last, data}
  logic [1:0] exp_addr  [$];  // {line, col}
  logic [2:0] exp1      [$];
  logic [1:0] exp_tab   [16];
  int   beat_seen = 0;
  int   last_seen = 0;
  int   en_seen   = 0;
  int   last1_seen = 0;
  logic stall_q = 1'b0;
  logic [2:0] stall_val = 3'd0;
  logic last_hs = 1'b0;
  logic [2:0] e;
  logic [1:0] a;
  logic [2:0] e1;

  // Monitor for dut0: address requests, beats, stall stability, DONE after LAST
  initial forever begin
    @(negedge clk);
    if (last_hs) check("done_after_last", 32'(bus0.O_DONE), 32'd1);
    last_hs = 1'b0;
    if (stall_q && bus0.O_SER_VLD)
      check("stall_hold", 32'({bus0.O_SER_LAST, bus0.O_SER_DATA}), 32'(stall_val));
    stall_q   = bus0.O_SER_VLD && !bus0.I_SER_RDY;
    stall_val = {bus0.O_SER_LAST, bus0.O_SER_DATA};
    if (bus0.O_RD_BRAM_EN) begin
      en_seen++;
      if (exp_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_en: got addr 0x%0h, want no request",
                 {bus0.O_RD_BRAM_LINE, bus0.O_RD_BRAM_COL});
      end else begin
        a = exp_addr.pop_front();
        check("en_addr", 32'({bus0.O_RD_BRAM_LINE, bus0.O_RD_BRAM_COL}), 32'(a));
      end
    end
    if (bus0.O_SER_VLD && bus0.I_SER_RDY) begin
      beat_seen++;
      if (bus0.O_SER_LAST) begin
        last_seen++;
        last_hs = 1'b1;
      end
      if (exp_beats.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got {last,data}=0x%0h, want no beat",
                 {bus0.O_SER_LAST, bus0.O_SER_DATA});
      end else begin
        e = exp_beats.pop_front();
        check($sformatf("beat_%0d", beat_seen), 32'({bus0.O_SER_LAST, bus0.O_SER_DATA}),
              32'(e));
      end
    end
  end

  // Monitor for dut1
  initial forever begin
    @(negedge clk);
    if (bus1.O_SER_VLD && bus1.I_SER_RDY) begin
      if (bus1.O_SER_LAST) last1_seen++;
      if (exp1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL msb_unexpected_beat: got 0x%0h, want no beat",
                 {bus1.O_SER_LAST, bus1.O_SER_DATA});
      end else begin
        e1 = exp1.pop_front();
        check("msb_beat", 32'({bus1.O_SER_LAST, bus1.O_SER_DATA}), 32'(e1));
      end
    end
  end

  task automatic push_run();
    for (int i = 0; i < 16; i++) exp_beats.push_back({(i == 15), exp_tab[i]});
    for (int w = 0; w < 4; w++) exp_addr.push_back(2'(w));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!bus0.O_DONE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus0.O_DONE), 32'd1);
  endtask

  task automatic drop_attn();
    @(posedge clk);
    #1 bus0.I_ATTN_END = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int b0, l0, e0, n;

  initial begin
    exp_tab = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0,
                2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hF0;
    mem[3] = 8'h01;
    rst_n = 1'b0;
    bus0.I_ATTN_END = 1'b0;
    bus1.I_ATTN_END = 1'b0;

    // Reset state
    #12;
    check("rst_en",   32'(bus0.O_RD_BRAM_EN), 32'd0);
    check("rst_vld",  32'(bus0.O_SER_VLD), 32'd0);
    check("rst_busy", 32'(bus0.O_BUSY), 32'd0);
    check("rst_done", 32'(bus0.O_DONE), 32'd0);
    check("rst_addr", 32'({bus0.O_RD_BRAM_LINE, bus0.O_RD_BRAM_COL}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full readout, ready tied high, with request latency check
    b0 = beat_seen;
    l0 = last_seen;
    push_run();
    @(posedge clk);
    #1 bus0.I_ATTN_END = 1'b1;
    @(negedge clk);
    check("en_not_early", 32'(bus0.O_RD_BRAM_EN), 32'd0);
    @(negedge clk);
    check("en_latency", 32'(bus0.O_RD_BRAM_EN), 32'd1);
    wait_done(200, "run1_done");
    check("run1_beats", 32'(beat_seen - b0), 32'd16);
    check("run1_last", 32'(last_seen - l0), 32'd1);
    check("run1_busy_in_done", 32'(bus0.O_BUSY), 32'd0);

    // Held level in DONE must not retrigger
    e0 = en_seen;
    repeat (10) @(negedge clk);
    check("done_no_retrigger", 32'(en_seen - e0), 32'd0);
    check("done_held", 32'(bus0.O_DONE), 32'd1);
    drop_attn();
    check("done_clear", 32'(bus0.O_DONE), 32'd0);

    // Backpressure plus a spurious read-valid during SHIFT
    bp_mode = 1'b1;
    b0 = beat_seen;
    l0 = last_seen;
    push_run();
    @(posedge clk);
    #1 bus0.I_ATTN_END = 1'b1;
    n = 0;
    while (!(beat_seen >= b0 + 2 && bus0.O_SER_VLD) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("spur_reached_shift", 32'(bus0.O_SER_VLD), 32'd1);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_done(400, "bp_done");
    check("bp_beats", 32'(beat_seen - b0), 32'd16);
    check("bp_last", 32'(last_seen - l0), 32'd1);
    bp_mode = 1'b0;
    drop_attn();

    // Abort during the second word's SHIFT, then restart from (0,0)
    l0 = last_seen;
    for (int i = 0; i < 4; i++) exp_beats.push_back({1'b0, exp_tab[i]});
    exp_addr.push_back(2'd0);
    exp_addr.push_back(2'd1);
    @(posedge clk);
    #1 bus0.I_ATTN_END = 1'b1;
    n = 0;
    while (exp_beats.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_word0_consumed", 32'(exp_beats.size()), 32'd0);
    @(posedge clk);
    #1 rdy_hold = 1'b1;
    n = 0;
    while (!bus0.O_SER_VLD && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_word1_vld", 32'(bus0.O_SER_VLD), 32'd1);
    check("abort_word1_beat0", 32'({bus0.O_SER_LAST, bus0.O_SER_DATA}), 32'd0);
    @(posedge clk);
    #1 bus0.I_ATTN_END = 1'b0;
    @(posedge clk);
    #1;
    check("abort_vld", 32'(bus0.O_SER_VLD), 32'd0);
    check("abort_busy", 32'(bus0.O_BUSY), 32'd0);
    check("abort_no_last", 32'(last_seen - l0), 32'd0);
    check("abort_addr_drained", 32'(exp_addr.size()), 32'd0);
    rdy_hold = 1'b0;
    repeat (3) @(posedge clk);
    b0 = beat_seen;
    l0 = last_seen;
    push_run();
    #1 bus0.I_ATTN_END = 1'b1;
    wait_done(200, "restart_done");
    check("restart_beats", 32'(beat_seen - b0), 32'd16);
    check("restart_last", 32'(last_seen - l0), 32'd1);
    drop_attn();

    // Async reset in the middle of WAIT for the second word
    e0 = en_seen;
    push_run();
    @(posedge clk);
    #1 bus0.I_ATTN_END = 1'b1;
    n = 0;
    while (en_seen != e0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_req", 32'(en_seen - e0), 32'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_en",   32'(bus0.O_RD_BRAM_EN), 32'd0);
    check("async_rst_addr", 32'({bus0.O_RD_BRAM_LINE, bus0.O_RD_BRAM_COL}), 32'd0);
    check("async_rst_vld",  32'({bus0.O_SER_VLD, bus0.O_SER_LAST, bus0.O_SER_DATA}), 32'd0);
    check("async_rst_busy", 32'(bus0.O_BUSY), 32'd0);
    check("async_rst_done", 32'(bus0.O_DONE), 32'd0);
    exp_beats.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    // Level already high at release counts as a rising edge
    b0 = beat_seen;
    l0 = last_seen;
    push_run();
    rst_n = 1'b1;
    #1;
    check("idle_after_release", 32'(bus0.O_BUSY), 32'd0);
    wait_done(200, "post_reset_done");
    check("post_reset_beats", 32'(beat_seen - b0), 32'd16);
    check("post_reset_last", 32'(last_seen - l0), 32'd1);
    drop_attn();

    // MSB-first instance, word 0xA5
    exp1.push_back({1'b0, 2'd2});
    exp1.push_back({1'b0, 2'd2});
    exp1.push_back({1'b0, 2'd1});
    exp1.push_back({1'b1, 2'd1});
    @(posedge clk);
    #1 bus1.I_ATTN_END = 1'b1;
    n = 0;
    while (!bus1.O_DONE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("msb_done", 32'(bus1.O_DONE), 32'd1);
    check("msb_last", 32'(last1_seen), 32'd1);
    check("msb_drained", 32'(exp1.size()), 32'd0);

    check("beats_drained", 32'(exp_beats.size()), 32'd0);
    check("addr_drained", 32'(exp_addr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/attn_result_serializer.md
Name: attn_result_serializer

Overview:
- Parametrised readback engine for the flash-attention result BRAM.
- Once the attention core signals completion, it walks every line/column word of the result memory and issues one read per word.
- Each returned wide word is captured and serialised LANES bits per beat onto a valid/ready stream for pin-limited FPGA observation or a downstream UART/debug link.
- Successor to the fixed 1-bit free-running readout. Adds configurable geometry, lane width, bit order, backpressure, last/done flags and abort.

Parameters:
- LINES, 64, number of BRAM lines (≥1).
- COLS, 8, words per line (≥1).
- WORD_W, 4096, width of one BRAM read word.
- LANES, 1, serial output width per beat; WORD_W % LANES must be 0, checked by elaboration assertion.
- MSB_FIRST, 0, 0 = shift out from bit 0 upward; 1 = from bit WORD_W-1 downward.

Ports:
- I_CLK, in, 1, clock.
- I_RST_N, in, 1, asynchronous active-low reset.
- I_ATTN_END, in, 1, level from attention core, high while results are valid.
- O_RD_BRAM_EN, out, 1, single-cycle read request pulse.
- O_RD_BRAM_LINE, out, $clog2(LINES) (min 1), line address of the request.
- O_RD_BRAM_COL, out, $clog2(COLS) (min 1), column address of the request.
- I_BRAM_RD_VLD, in, 1, read data valid (arbitrary latency ≥1 cycle after EN).
- I_BRAM_RD_MAT, in, WORD_W, read data, sampled only when I_BRAM_RD_VLD is high.
- O_SER_VLD, out, 1, serial beat valid.
- O_SER_DATA, out, LANES, serial beat payload.
- I_SER_RDY, in, 1, downstream ready.
- O_SER_LAST, out, 1, high with the final beat of the final word.
- O_BUSY, out, 1, high in any state except IDLE and DONE.
- O_DONE, out, 1, high in DONE.

Behaviour:
- Reset (async, I_RST_N low): state IDLE. All outputs 0. Line, column and beat counters 0. Shift register 0. Edge register for I_ATTN_END = 0.
- States: IDLE, REQ, WAIT, SHIFT, DONE. All outputs are registered or decoded from state and registers; there is no combinational path from inputs to outputs.
- IDLE:
  - A rising edge of I_ATTN_END (sampled high, previous sample low) sets line=0, col=0 and moves to REQ.
  - I_ATTN_END already high coming out of reset counts as a rising edge.
- REQ:
  - O_RD_BRAM_EN = 1 for exactly this one cycle, with the current line/col on the address ports. Next state WAIT.
  - Address ports hold their values until the next REQ.
- WAIT:
  - On I_BRAM_RD_VLD=1, load I_BRAM_RD_MAT into the shift register, set beat=0 and go to SHIFT.
  - Otherwise stay; there is no timeout.
  - I_BRAM_RD_VLD in any state other than WAIT is ignored.
- SHIFT:
  - O_SER_VLD = 1.
  - O_SER_DATA = shift[LANES-1:0] (MSB_FIRST=0) or shift[WORD_W-1 -: LANES] (MSB_FIRST=1).
  - On O_SER_VLD && I_SER_RDY: shift by LANES toward the output end and increment beat.
  - While I_SER_RDY=0, O_SER_DATA and O_SER_LAST must hold stable.
  - When the handshake occurs on beat == WORD_W/LANES-1:
    - if col==COLS-1 and line==LINES-1, go to DONE;
    - else if col==COLS-1, set col=0, line+1, go to REQ;
    - else col+1, go to REQ.
- O_SER_LAST = SHIFT && beat==WORD_W/LANES-1 && col==COLS-1 && line==LINES-1.
- DONE:
  - O_DONE = 1, O_SER_VLD = 0.
  - Stay until I_ATTN_END goes low, then go to IDLE.
  - A new rising edge is required to start another readout.
- Abort: I_ATTN_END low in REQ, WAIT or SHIFT sends the FSM to IDLE next cycle.
  - O_SER_VLD drops, counters clear, no O_SER_LAST is emitted.
  - A read response still in flight is ignored.
- Latency:
  - Rising edge sampled at cycle t gives O_RD_BRAM_EN high at t+1.
  - VLD sampled at cycle k gives first O_SER_VLD at k+1.
  - Last-beat handshake at cycle m gives the next O_RD_BRAM_EN at m+1.
- Totals: LINES*COLS words, LINES*COLS*WORD_W/LANES beats, exactly one O_SER_LAST pulse per completed readout.
- Counters are sized so that line LINES-1 and col COLS-1 never wrap before the explicit terminal compare (non-power-of-two LINES/COLS supported).

Test Plan:
- LINES=2, COLS=2, WORD_W=8, LANES=2, MSB_FIRST=0, RDY tied 1, BRAM returns 0xA5/0x3C/0xF0/0x01 with 2-cycle latency. Required: EN pulses at (0,0),(0,1),(1,0),(1,1); beats 1,1,2,2 then 0,3,3,0 then 0,0,3,3 then 1,0,0,0; 16 beats total; LAST on beat 16; O_DONE high the next cycle.
- Same config with MSB_FIRST=1 and word 0xA5. Required: beats 2,2,1,1.
- Backpressure: RDY toggles 1,0,0,1 while in SHIFT. Required: DATA/LAST stable through RDY=0 cycles; no beat lost or duplicated; beat count still 16.
- Abort: I_ATTN_END drops during the 2nd word's SHIFT. Required: O_SER_VLD 0 and O_BUSY 0 next cycle; no LAST. A re-raise restarts at line 0, col 0.
- Ignored data and no retrigger: a spurious I_BRAM_RD_VLD pulse in SHIFT leaves the shift register unchanged. I_ATTN_END held high in DONE gives no new EN; dropping then raising it starts a fresh readout.
- Async reset asserted mid-WAIT. Required: all outputs 0 immediately, independent of the clock; state IDLE after release.
